mmio_uart_port: RTL
===================

// Module: mmio_uart_port
// PURPOSE
//  Memory-mapped I/O peripheral that sits downstream of the MIPS datapath, beside DataMemory.
//  It shares the processor's ALU address bus, store data, MemWrite and MemRead.
//  It provides four registers: a TX FIFO feeding a UART serializer, a status register,
//  a synchronized PortIn register and a PortOut latch.
//  The top level muxes ReadData into the MemtoReg path whenever Hit=1.
// PARAMETERS
//  BASE_ADDR     32'h1001_0100  base of the 16-byte register window; bits [3:0] must be 0
//  CLKS_PER_BIT  16             clk cycles per UART bit; must be >= 2
//  FIFO_DEPTH    4              TX FIFO entries; must be a power of 2, >= 2
// PORTS
//  clk        in   1   system clock; all state updates on the rising edge
//  reset      in   1   synchronous, active-high reset
//  Address    in   32  byte address (ALU result)
//  WriteData  in   32  store data (register file ReadData2)
//  MemWrite   in   1   store strobe
//  MemRead    in   1   load strobe
//  PortIn     in   8   asynchronous external input
//  Hit        out  1   combinational; 1 when Address[31:4]==BASE_ADDR[31:4]
//  ReadData   out  32  combinational read data; 0 unless MemRead && Hit
//  PortOut    out  32  registered output latch
//  TxSerial   out  1   registered UART line; idles high
// BEHAVIOUR
//  Register map, selected by Address[3:2]. Address[1:0] is ignored.
//   0x0 TXDATA   W: push WriteData[7:0] into the FIFO. R: returns 0.
//   0x4 STATUS   R: {25'b0, count[2:0] at [6:4], ovf[3], busy[2], empty[1], full[0]}.
//                   The count field saturates at 7.
//                W: any write clears ovf.
//   0x8 PORTIN   R: {24'b0, PortIn after 2-flop synchronizer}. W: ignored.
//   0xC PORTOUT  R/W: full 32-bit latch. The new value appears on PortOut one edge after the write.
//  Writes take effect only when MemWrite && Hit at the clock edge.
//  Reads are combinational and have no side effects.
//  Reset values: PortOut=0, TxSerial=1, FIFO empty, ovf=0, sync flops=0, FSM=IDLE.
//   The resulting STATUS value is 0x2.
//   Reset asserted mid-frame aborts the frame: TxSerial=1 at the next edge, queued bytes discarded.
//  FIFO:
//   - Push while full (full sampled before any same-cycle pop) is dropped and sets ovf (sticky).
//   - Push and pop in the same cycle on a non-full FIFO leave count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  TX FSM: states IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1.
//   - IDLE: TxSerial=1. If the FIFO is non-empty, the next edge pops the head into the shifter,
//     drives TxSerial=0 and enters START.
//   - START: holds 0 for CLKS_PER_BIT cycles, then enters DATA and outputs shifter bit0.
//   - DATA: sends 8 bits LSB first, each held CLKS_PER_BIT cycles, then enters STOP with TxSerial=1.
//   - STOP: holds 1 for CLKS_PER_BIT cycles.
//     At the end, if the FIFO is non-empty: pop and go to START (no idle gap). Otherwise go to IDLE.
//   - busy = (state != IDLE).
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
//   - Latency: a push to an empty FIFO at edge k while IDLE gives TxSerial=0 from edge k+1.
//  PORTIN sync: a value applied before edge k is readable after edge k+1 (two flops).
// TESTING
//  1. Reset:
//     assert reset for 2 cycles -> TxSerial=1, PortOut=0, STATUS read = 0x00000002.
//  2. Single byte, CLKS_PER_BIT=16:
//     store 0x55 to base+0x0 at edge k -> TxSerial=0 for edges k+1..k+16.
//     Then bits 1,0,1,0,1,0,1,0, 16 cycles each, then 1 for 16 cycles.
//     busy=1 for exactly 160 cycles.
//  3. Overflow:
//     6 back-to-back stores (0x01..0x06) to TXDATA while IDLE -> 0x01..0x05 are sent
//     as contiguous frames; 0x06 is dropped.
//     STATUS bit3=1 after the 6th store; a write to STATUS clears it to 0.
//  4. PortOut:
//     store 0xDEADBEEF to base+0xC -> PortOut=0xDEADBEEF after the edge;
//     load from base+0xC returns 0xDEADBEEF.
//  5. PortIn:
//     drive 0xA5 -> base+0x8 reads 0x0 for 1 cycle, then 0x000000A5.
//     A load at base+0x10 gives Hit=0, ReadData=0.
//  6. Reset mid-frame:
//     queue 2 bytes, assert reset during the 3rd data bit -> TxSerial=1 next edge,
//     STATUS=0x2, no further frame is sent.

Source files
------------

// File: rtl/mmio_uart_port.sv
// Memory-mapped UART transmitter and GPIO block on the MIPS data bus.
// It holds a TX FIFO with a serializer, a status register, a synchronized input port and an output latch.
module mmio_uart_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic [31:0] PortOut,
    output logic        TxSerial
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    txState_t             stateReg, stateNext;
    logic [BIT_W-1:0]     bitCntReg, bitCntNext;
    logic [2:0]           bitIdxReg, bitIdxNext;
    logic [7:0]           shiftReg, shiftNext;
    logic                 txReg, txNext;
    logic                 pop;
    logic                 lastTick;

    logic [7:0]           fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtrReg, rdPtrReg;
    logic [CNT_W-1:0]     countReg;
    logic                 ovfReg;
    logic                 fifoFull, fifoEmpty;
    logic [7:0]           headByte;

    logic [7:0]           syncAReg, syncBReg;
    logic [31:0]          portOutReg;

    logic [1:0]           regSel;
    logic                 writeEn, pushReq, pushOk;
    logic [31:0]          count32;
    logic [2:0]           countSat;
    logic                 unusedAddrBits;

    assign Hit            = (Address[31:4] == BASE_ADDR[31:4]);
    assign regSel         = Address[3:2];
    assign unusedAddrBits = ^Address[1:0];
    assign writeEn        = MemWrite && Hit;
    assign pushReq        = writeEn && (regSel == 2'd0);
    assign fifoFull       = (countReg == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty      = (countReg == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign pushOk         = pushReq && !fifoFull;
    assign headByte       = fifoMem[rdPtrReg];
    assign lastTick       = (bitCntReg == BIT_W'(CLKS_PER_BIT - 1));

    assign count32        = 32'(countReg);
    assign countSat       = (count32 > 32'd7) ? 3'd7 : count32[2:0];

    assign TxSerial       = txReg;
    assign PortOut        = portOutReg;

    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtrReg] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            ovfReg   <= 1'b0;
        end else begin
            if (pushOk) wrPtrReg <= wrPtrReg + 1'b1;
            if (pop)    rdPtrReg <= rdPtrReg + 1'b1;
            case ({pushOk, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
            if (writeEn && (regSel == 2'd1)) begin
                ovfReg <= 1'b0;
            end else if (pushReq && fifoFull) begin
                ovfReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            syncAReg   <= '0;
            syncBReg   <= '0;
            portOutReg <= '0;
        end else begin
            syncAReg <= PortIn;
            syncBReg <= syncAReg;
            if (writeEn && (regSel == 2'd3)) begin
                portOutReg <= WriteData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg  <= IDLE;
            bitCntReg <= '0;
            bitIdxReg <= '0;
            shiftReg  <= '0;
            txReg     <= 1'b1;
        end else begin
            stateReg  <= stateNext;
            bitCntReg <= bitCntNext;
            bitIdxReg <= bitIdxNext;
            shiftReg  <= shiftNext;
            txReg     <= txNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        bitCntNext = bitCntReg;
        bitIdxNext = bitIdxReg;
        shiftNext  = shiftReg;
        txNext     = txReg;
        pop        = 1'b0;
        case (stateReg)
            IDLE: begin
                txNext     = 1'b1;
                bitCntNext = '0;
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shiftNext = headByte;
                    txNext    = 1'b0;
                    stateNext = START;
                end
            end
            START: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    bitIdxNext = '0;
                    txNext     = shiftReg[0];
                    stateNext  = DATA;
                end else begin
                    bitCntNext = bitCntReg + 1'b1;
                end
            end
            DATA: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    if (bitIdxReg == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdxReg + 1'b1;
                        shiftNext  = shiftReg >> 1;
                        txNext     = shiftReg[1];
                    end
                end else begin
                    bitCntNext = bitCntReg + 1'b1;
                end
            end
            STOP: begin
                if (lastTick) begin
                    bitCntNext = '0;
                    // Back-to-back frames: go straight to the next start bit with no idle gap.
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shiftNext = headByte;
                        txNext    = 1'b0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    bitCntNext = bitCntReg + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (regSel)
                2'd1:    ReadData = {25'b0, countSat, ovfReg, (stateReg != IDLE), fifoEmpty, fifoFull};
                2'd2:    ReadData = {24'b0, syncBReg};
                2'd3:    ReadData = portOutReg;
                default: ReadData = '0;
            endcase
        end
    end
endmodule
